// File: rtl/reg_writeback_unit.sv
// Register-file write-port driver: merges load returns and buffered ALU results
// into one registered write per cycle (WE3/AD3/WD3).
module reg_writeback_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_word,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_off,
  output logic            ld_err,
  input  logic [4:0]      q_rd,
  output logic            q_hit,
  output logic            busy,
  output logic            WE3,
  output logic [4:0]      AD3,
  output logic [XLEN-1:0] WD3
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [4:0]       rd_mem_q   [FIFO_DEPTH];
  logic [XLEN-1:0]  data_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             we3_q, we3_d, ld_err_q, ld_err_d;
  logic [4:0]       ad3_q, ad3_d;
  logic [XLEN-1:0]  wd3_q, wd3_d;

  logic            fifo_empty_c, alu_live_c, push_c, pop_c, ld_ok_c;
  logic [XLEN-1:0] ld_data_c;
  logic [7:0]      ld_byte_c;
  logic [15:0]     ld_half_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (32'(p) == FIFO_DEPTH - 1) return '0;
    return p + PTR_W'(1);
  endfunction

  assign fifo_empty_c = (count_q == '0);
  assign alu_ready    = (count_q < CNT_W'(FIFO_DEPTH));
  assign alu_live_c   = alu_valid && alu_ready && (alu_rd != 5'd0);
  assign busy         = !fifo_empty_c;
  assign WE3          = we3_q;
  assign AD3          = ad3_q;
  assign WD3          = wd3_q;
  assign ld_err       = ld_err_q;

  // Load lane extraction and legality check
  always_comb begin
    ld_byte_c = ld_word[{ld_off, 3'b000} +: 8];
    ld_half_c = ld_word[{ld_off[1], 4'b0000} +: 16];
    ld_ok_c   = 1'b0;
    ld_data_c = '0;
    case (ld_funct3)
      3'b000: begin ld_ok_c = 1'b1;              ld_data_c = {{(XLEN-8){ld_byte_c[7]}}, ld_byte_c}; end
      3'b001: begin ld_ok_c = !ld_off[0];        ld_data_c = {{(XLEN-16){ld_half_c[15]}}, ld_half_c}; end
      3'b010: begin ld_ok_c = (ld_off == 2'd0);  ld_data_c = ld_word; end
      3'b100: begin ld_ok_c = 1'b1;              ld_data_c = {{(XLEN-8){1'b0}}, ld_byte_c}; end
      3'b101: begin ld_ok_c = !ld_off[0];        ld_data_c = {{(XLEN-16){1'b0}}, ld_half_c}; end
      default: begin ld_ok_c = 1'b0;             ld_data_c = '0; end
    endcase
  end

  // Write-slot arbitration: load, then FIFO head, then ALU bypass
  always_comb begin
    we3_d    = 1'b0;
    ad3_d    = ad3_q;
    wd3_d    = wd3_q;
    ld_err_d = 1'b0;
    pop_c    = 1'b0;
    push_c   = 1'b0;
    if (ld_valid) begin
      ld_err_d = !ld_ok_c;
      if (ld_ok_c && (ld_rd != 5'd0)) begin
        we3_d = 1'b1;
        ad3_d = ld_rd;
        wd3_d = ld_data_c;
      end
      push_c = alu_live_c;
    end else if (!fifo_empty_c) begin
      pop_c  = 1'b1;
      we3_d  = 1'b1;
      ad3_d  = rd_mem_q[rd_ptr_q];
      wd3_d  = data_mem_q[rd_ptr_q];
      push_c = alu_live_c;
    end else if (alu_live_c) begin
      we3_d = 1'b1;
      ad3_d = alu_rd;
      wd3_d = alu_data;
    end
  end

  always_comb begin
    rd_ptr_d = pop_c  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push_c ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    count_d  = count_q;
    if (push_c && !pop_c) count_d = count_q + CNT_W'(1);
    else if (pop_c && !push_c) count_d = count_q - CNT_W'(1);
  end

  // Hazard query against live FIFO entries only
  always_comb begin
    logic             hit;
    logic [PTR_W-1:0] idx;
    hit = 1'b0;
    idx = '0;
    for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
      idx = PTR_W'((32'(rd_ptr_q) + k) % FIFO_DEPTH);
      if ((k < 32'(count_q)) && (rd_mem_q[idx] == q_rd)) hit = 1'b1;
    end
    q_hit = hit && (q_rd != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      we3_q    <= 1'b0;
      ad3_q    <= '0;
      wd3_q    <= '0;
      ld_err_q <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      we3_q    <= we3_d;
      ad3_q    <= ad3_d;
      wd3_q    <= wd3_d;
      ld_err_q <= ld_err_d;
    end
  end

  // Storage needs no reset; validity is tracked by count_q
  always_ff @(posedge clk) begin
    if (push_c && !rst) begin
      rd_mem_q[wr_ptr_q]   <= alu_rd;
      data_mem_q[wr_ptr_q] <= alu_data;
    end
  end

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed bench for reg_writeback_unit with hand-computed expected values.
module tb_reg_writeback_unit;

  logic        clk = 1'b0;
  logic        rst, alu_valid, alu_ready, ld_valid, ld_err, q_hit, busy, WE3;
  logic [4:0]  alu_rd, ld_rd, q_rd, AD3;
  logic [31:0] alu_data, ld_word, WD3;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_off;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_writeback_unit #(.XLEN(32), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_word(ld_word), .ld_funct3(ld_funct3),
    .ld_off(ld_off), .ld_err(ld_err), .q_rd(q_rd), .q_hit(q_hit), .busy(busy),
    .WE3(WE3), .AD3(AD3), .WD3(WD3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = 5'd0; ld_funct3 = 3'b010; ld_off = 2'd0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    alu_valid = 1'b1; alu_rd = rd; alu_data = d;
  endtask

  task automatic ld(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off);
    ld_valid = 1'b1; ld_rd = rd; ld_funct3 = f3; ld_off = off;
  endtask

  task automatic wr(input string tag, input logic [4:0] rd, input logic [31:0] d);
    chk({tag, ".we"}, 32'(WE3), 32'd1);
    chk({tag, ".ad"}, 32'(AD3), 32'(rd));
    chk({tag, ".wd"}, WD3, d);
  endtask

  initial begin
    idle();
    rst = 1'b1; q_rd = 5'd0; ld_word = 32'h8000_7F80;
    step(); step();
    chk("rst.we", 32'(WE3), 0);
    chk("rst.wd", WD3, 0);
    chk("rst.ad", 32'(AD3), 0);
    chk("rst.ready", 32'(alu_ready), 1);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.err", 32'(ld_err), 0);
    rst = 1'b0;

    // Bypass
    alu(5'd5, 32'h0000_1234); step(); idle();
    wr("byp", 5'd5, 32'h0000_1234);
    chk("byp.busy", 32'(busy), 0);

    // Load extraction
    ld(5'd10, 3'b000, 2'd0); step(); wr("lb", 5'd10, 32'hFFFF_FF80);
    ld(5'd10, 3'b101, 2'd2); step(); wr("lhu", 5'd10, 32'h0000_8000);
    ld(5'd10, 3'b001, 2'd2); step(); wr("lh", 5'd10, 32'hFFFF_8000);
    ld(5'd10, 3'b100, 2'd1); step(); wr("lbu", 5'd10, 32'h0000_007F);
    idle();

    // Conflict: loads win, ALU results queue then drain in order
    ld(5'd11, 3'b010, 2'd0); alu(5'd1, 32'h111); step();
    wr("cf.l11", 5'd11, 32'h8000_7F80);
    chk("cf.busy1", 32'(busy), 1);
    chk("cf.ready1", 32'(alu_ready), 1);
    ld(5'd12, 3'b010, 2'd0); alu(5'd2, 32'h222); step();
    wr("cf.l12", 5'd12, 32'h8000_7F80);
    chk("cf.ready2", 32'(alu_ready), 0);
    ld(5'd13, 3'b010, 2'd0); alu(5'd3, 32'h333); step();
    wr("cf.l13", 5'd13, 32'h8000_7F80);
    chk("cf.ready3", 32'(alu_ready), 0);
    ld_valid = 1'b0; step();
    wr("cf.a1", 5'd1, 32'h111);
    chk("cf.ready4", 32'(alu_ready), 1);
    step(); alu_valid = 1'b0;
    wr("cf.a2", 5'd2, 32'h222);
    step();
    wr("cf.a3", 5'd3, 32'h333);
    chk("cf.busy_end", 32'(busy), 0);
    idle(); step();
    chk("cf.idle_we", 32'(WE3), 0);
    chk("cf.idle_ad", 32'(AD3), 3);

    // x0 and error handling
    alu(5'd0, 32'hDEAD); step(); idle();
    chk("x0alu.we", 32'(WE3), 0);
    chk("x0alu.busy", 32'(busy), 0);
    ld(5'd4, 3'b010, 2'd1); step(); idle();
    chk("lwmis.err", 32'(ld_err), 1);
    chk("lwmis.we", 32'(WE3), 0);
    step();
    chk("err.pulse", 32'(ld_err), 0);
    ld(5'd4, 3'b011, 2'd0); step(); idle();
    chk("f3bad.err", 32'(ld_err), 1);
    chk("f3bad.we", 32'(WE3), 0);
    ld(5'd0, 3'b010, 2'd0); step(); idle();
    chk("x0ld.we", 32'(WE3), 0);
    chk("x0ld.err", 32'(ld_err), 0);

    // Hazard query, then reset discards buffered entries
    ld(5'd20, 3'b010, 2'd0); alu(5'd7, 32'h777); step();
    ld(5'd21, 3'b010, 2'd0); alu(5'd9, 32'h999); step(); idle();
    chk("hz.busy", 32'(busy), 1);
    q_rd = 5'd9; #1 chk("hz.hit9", 32'(q_hit), 1);
    q_rd = 5'd7; #1 chk("hz.hit7", 32'(q_hit), 1);
    q_rd = 5'd8; #1 chk("hz.miss8", 32'(q_hit), 0);
    q_rd = 5'd9;
    rst = 1'b1; step(); rst = 1'b0;
    chk("hzr.we", 32'(WE3), 0);
    chk("hzr.busy", 32'(busy), 0);
    chk("hzr.hit", 32'(q_hit), 0);
    chk("hzr.ready", 32'(alu_ready), 1);
    step();
    chk("hzr.we1", 32'(WE3), 0);
    step();
    chk("hzr.we2", 32'(WE3), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
